// File: rtl/fetch_unit_pkg.sv
// Shared constants, payload type and address legality helper for the instruction-fetch block.
package fetch_unit_pkg;

    localparam logic [31:0] IMEM_BASE  = 32'h0100_0000;
    localparam logic [31:0] IMEM_LAST  = 32'h0100_09FC;
    localparam logic [31:0] RESET_PC   = 32'h0100_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam int          IMEM_WORDS = int'((IMEM_LAST - IMEM_BASE) / WORD_BYTES) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_pkt_t;

    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr >= IMEM_BASE) && (addr <= IMEM_LAST) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory, redirect and decode-side signals of the fetch unit; master is the fetch side.
interface fetch_unit_if;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        output imem_rd, imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
        input  imem_instr, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_rd, imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
        output imem_instr, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry output register + skid buffer carrying {pc,instr}; zero added latency, flush drops both.
// Upstream guarantees no write when both entries are full and nothing is dequeued.
module fetch_skid_buf
    import fetch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    input  fetch_pkt_t in_pkt,
    input  logic       out_ready,
    output logic       out_valid,
    output fetch_pkt_t out_pkt,
    output logic       skid_valid
);

    fetch_pkt_t skid_pkt;
    logic       deq;

    assign deq = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pkt    <= '0;
            skid_valid <= 1'b0;
            skid_pkt   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (deq && skid_valid) begin
            // Older skid entry advances first; a new response backfills the skid slot.
            out_pkt    <= skid_pkt;
            skid_valid <= in_valid;
            if (in_valid) begin
                skid_pkt <= in_pkt;
            end
        end else if (deq || !out_valid) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_pkt <= in_pkt;
            end
        end else if (in_valid) begin
            skid_valid <= 1'b1;
            skid_pkt   <= in_pkt;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one read per cycle when buffer room allows, redirect and fault handling.
// Response visible on out_* two cycles after issue; stalls issue when output + skid + in-flight would exceed 2.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        pending_q;
    logic [31:0] pending_pc_q;
    logic        fault_q;
    logic [31:0] fault_pc_q;

    logic        issue;
    logic [31:0] issue_addr;
    logic        fault_set;
    logic        redirect_ok;
    logic        out_valid;
    logic        skid_valid;
    logic        deq;
    logic [2:0]  occ;
    fetch_pkt_t  resp_pkt;
    fetch_pkt_t  out_pkt;

    assign redirect_ok = addr_legal(bus.redirect_pc);
    assign deq         = out_valid && bus.out_ready;
    assign occ         = {2'b00, out_valid} + {2'b00, skid_valid} + {2'b00, pending_q} - {2'b00, deq};

    always_comb begin
        issue      = 1'b0;
        issue_addr = pc_q;
        pc_d       = pc_q;
        fault_set  = 1'b0;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
            if (redirect_ok) begin
                issue      = 1'b1;
                issue_addr = bus.redirect_pc;
                pc_d       = bus.redirect_pc + WORD_BYTES;
            end
        end else if (!fault_q) begin
            if (!addr_legal(pc_q)) begin
                fault_set = 1'b1;
            end else if (occ <= 3'd1) begin
                issue = 1'b1;
                pc_d  = pc_q + WORD_BYTES;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            fault_q      <= 1'b0;
            fault_pc_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            pending_q <= issue;
            if (issue) begin
                pending_pc_q <= issue_addr;
            end
            if (bus.redirect_valid) begin
                fault_q <= !redirect_ok;
                if (!redirect_ok) begin
                    fault_pc_q <= bus.redirect_pc;
                end
            end else if (fault_set) begin
                fault_q    <= 1'b1;
                fault_pc_q <= pc_q;
            end
        end
    end

    // A redirect kills the response landing this cycle along with everything buffered.
    assign resp_pkt = '{pc: pending_pc_q, instr: bus.imem_instr};

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.redirect_valid),
        .in_valid   (pending_q && !bus.redirect_valid),
        .in_pkt     (resp_pkt),
        .out_ready  (bus.out_ready),
        .out_valid  (out_valid),
        .out_pkt    (out_pkt),
        .skid_valid (skid_valid)
    );

    assign bus.imem_rd   = issue && !rst;
    assign bus.imem_addr = (issue && !rst) ? issue_addr : pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_pkt.pc;
    assign bus.out_instr = out_pkt.instr;
    assign bus.fault     = fault_q;
    assign bus.fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model, directed scenarios, randomized stall/redirect traffic, scoreboard.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [IMEM_WORDS];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          xfers  = 0;
    int          rds    = 0;
    logic [31:0] last_pc = '0;

    function automatic logic tb_legal(input logic [31:0] a);
        return (a >= 32'h0100_0000) && (a <= 32'h0100_09FC) && (a % 4 == 0);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int idx;
        idx = int'((a - 32'h0100_0000) >> 2);
        if (idx < 0 || idx >= IMEM_WORDS) return 32'hDEAD_BEEF;
        return mem[idx];
    endfunction

    always @(posedge clk) begin
        if (bus.imem_rd) bus.imem_instr <= mem_word(bus.imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d, expected at most %0d", name, act, lim);
        end
    endtask

    // Reference stream: after a (re)start at a legal address, decode sees consecutive words to the window end.
    task automatic load_expect(input logic [31:0] start);
        exp_q.delete();
        if (tb_legal(start)) begin
            for (logic [32:0] a = {1'b0, start}; a <= 33'h0_0100_09FC; a += 33'd4) exp_q.push_back(a[31:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        load_expect(target);
    endtask

    // Monitor: scoreboard pops, hold-stability, capacity and read-address legality.
    int          inflight = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc, prev_instr;

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            inflight   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                check("hold_pc", bus.out_pc, prev_pc);
                check("hold_instr", bus.out_instr, prev_instr);
            end
            if (bus.redirect_valid) begin
                inflight = 0;
            end else begin
                check_le("inflight", inflight, 2);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_xfer: got pc %h, expected none", bus.out_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_pc", bus.out_pc, e);
                        check("xfer_instr", bus.out_instr, mem_word(e));
                    end
                    last_pc = bus.out_pc;
                    xfers++;
                    inflight--;
                end
            end
            if (bus.imem_rd) begin
                check("rd_addr_legal", {31'b0, tb_legal(bus.imem_addr)}, 32'd1);
                inflight++;
                rds++;
            end
            prev_stall = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
            prev_pc    = bus.out_pc;
            prev_instr = bus.out_instr;
        end
    end

    initial begin
        int x0;
        int r0;
        logic [31:0] tgt;

        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;
        bus.imem_instr     = '0;
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_rd", {31'b0, bus.imem_rd}, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_fault", {31'b0, bus.fault}, 32'd0);
        check("rst_fault_pc", bus.fault_pc, 32'd0);

        // Release: first read in the same cycle, data visible two cycles later.
        step();
        rst = 1'b0;
        load_expect(32'h0100_0000);
        @(negedge clk);
        check("first_rd", {31'b0, bus.imem_rd}, 32'd1);
        check("first_addr", bus.imem_addr, 32'h0100_0000);
        step();
        @(negedge clk);
        check("first_valid_t1", {31'b0, bus.out_valid}, 32'd0);
        step();
        @(negedge clk);
        check("first_valid_t2", {31'b0, bus.out_valid}, 32'd1);
        check("first_out_pc", bus.out_pc, 32'h0100_0000);
        #1;
        x0 = xfers;
        repeat (20) begin
            @(negedge clk);
            #1;
        end
        check("throughput", xfers - x0, 32'd20);

        // Stall for 5 cycles.
        step();
        bus.out_ready = 1'b0;
        r0 = rds;
        repeat (5) step();
        check_le("stall_reads", rds - r0, 2);
        bus.out_ready = 1'b1;
        repeat (6) step();

        // Redirect while both entries are full.
        bus.out_ready = 1'b0;
        repeat (3) step();
        do_redirect(32'h0100_0100);
        @(negedge clk);
        check("redir_rd", {31'b0, bus.imem_rd}, 32'd1);
        check("redir_addr", bus.imem_addr, 32'h0100_0100);
        step();
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        @(negedge clk);
        check("redir_valid_t1", {31'b0, bus.out_valid}, 32'd0);
        step();
        @(negedge clk);
        check("redir_valid_t2", {31'b0, bus.out_valid}, 32'd1);
        check("redir_out_pc", bus.out_pc, 32'h0100_0100);
        repeat (10) step();

        // Run off the end of the window.
        do_redirect(32'h0100_09E0);
        step();
        bus.redirect_valid = 1'b0;
        repeat (20) step();
        @(negedge clk);
        check("end_fault", {31'b0, bus.fault}, 32'd1);
        check("end_fault_pc", bus.fault_pc, 32'h0100_0A00);
        check("end_rd", {31'b0, bus.imem_rd}, 32'd0);
        check("end_last_pc", last_pc, 32'h0100_09FC);
        check("end_drained", exp_q.size(), 32'd0);

        // Illegal redirect targets, then recovery.
        step();
        do_redirect(32'h0100_0102);
        @(negedge clk);
        check("misal_rd", {31'b0, bus.imem_rd}, 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("misal_fault", {31'b0, bus.fault}, 32'd1);
        check("misal_fault_pc", bus.fault_pc, 32'h0100_0102);
        step();
        do_redirect(32'h00FF_FFFC);
        @(negedge clk);
        check("below_rd", {31'b0, bus.imem_rd}, 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("below_fault", {31'b0, bus.fault}, 32'd1);
        check("below_fault_pc", bus.fault_pc, 32'h00FF_FFFC);
        repeat (3) step();
        @(negedge clk);
        check("faulted_rd", {31'b0, bus.imem_rd}, 32'd0);
        step();
        do_redirect(32'h0100_0000);
        @(negedge clk);
        check("recover_rd", {31'b0, bus.imem_rd}, 32'd1);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("recover_fault", {31'b0, bus.fault}, 32'd0);
        step();
        @(negedge clk);
        check("recover_out_pc", bus.out_pc, 32'h0100_0000);

        // Randomized stalls and redirects.
        for (int c = 0; c < 1500; c++) begin
            step();
            bus.redirect_valid = 1'b0;
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                tgt = 32'h0100_0000 + 32'($urandom_range(0, IMEM_WORDS - 1)) * 32'd4;
                if ($urandom_range(0, 7) == 0) tgt = tgt + 32'd2;
                do_redirect(tgt);
            end
        end

        // Asynchronous reset with both entries full and a fault pending.
        step();
        bus.out_ready = 1'b0;
        do_redirect(32'h0100_09F8);
        step();
        bus.redirect_valid = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check("prerst_valid", {31'b0, bus.out_valid}, 32'd1);
        check("prerst_fault", {31'b0, bus.fault}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("arst_rd", {31'b0, bus.imem_rd}, 32'd0);
        check("arst_fault", {31'b0, bus.fault}, 32'd0);
        check("arst_out_pc", bus.out_pc, 32'd0);
        step();
        step();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        load_expect(32'h0100_0000);
        @(negedge clk);
        check("restart_rd", {31'b0, bus.imem_rd}, 32'd1);
        check("restart_addr", bus.imem_addr, 32'h0100_0000);
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator that drives the synchronous instruction memory (word-addressed, 1-cycle read latency, window 0x01000000–0x010009FF).
- Holds the PC and issues one read per cycle when there is room.
- Buffers returning words behind a valid/ready handshake toward decode.
- Handles branch/jump redirects and flags out-of-window or misaligned fetches.

Parameters:
- IMEM_BASE, 32'h01000000, first valid instruction byte address.
- IMEM_LAST, 32'h010009FC, last valid word address (inclusive).
- RESET_PC, 32'h01000000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_rd  out  1  read strobe to instruction memory.
- imem_addr  out  32  byte address to memory; always word aligned when imem_rd=1.
- imem_instr  in  32  memory read data, valid the cycle after an issued read.
- redirect_valid  in  1  load new PC this cycle (branch/jump/trap).
- redirect_pc  in  32  target address.
- out_valid  out  1  out_instr/out_pc hold a fetched instruction.
- out_ready  in  1  decode accepts; transfer occurs when out_valid && out_ready.
- out_instr  out  32  fetched instruction word.
- out_pc  out  32  address of out_instr.
- fault  out  1  sticky: fetch address out of window or misaligned.
- fault_pc  out  32  offending address, captured when fault sets.

Behaviour:
- Reset (async, on assertion):
  - pc_q=RESET_PC; imem_rd=0.
  - out_valid=0, out_instr=0, out_pc=0.
  - skid empty; pending=0; fault=0, fault_pc=0.
- First read is issued in the first clock cycle after rst deasserts.
- Request/response timing:
  - A request at cycle t drives imem_rd=1 and imem_addr=pc.
  - The response is sampled from imem_instr in cycle t+1.
  - The response is visible on out_* from cycle t+2.
  - pending_q marks that a response arrives next cycle; pending_pc_q tags its address.
- Storage: output register plus one skid entry (capacity 2).
  - A response with the output register empty, or being dequeued this cycle, goes to the output register.
  - Otherwise it goes to the skid entry.
  - On dequeue, the skid entry moves to the output register.
- Issue rule: occ = out_valid + skid_valid + pending_q − (out_valid && out_ready).
  - Issue when occ ≤ 1, fault=0, and pc is legal.
  - On issue, pc_q <= pc+4.
  - With out_ready held high, throughput is one instruction per cycle.
- Legal address: IMEM_BASE ≤ addr ≤ IMEM_LAST and addr[1:0]==0.
- Illegal pc at issue time:
  - Do not issue.
  - Set fault=1 and fault_pc=pc.
  - No further issues until redirect or reset.
  - Already-buffered instructions still drain.
- Sequential overrun: after issuing IMEM_LAST, pc becomes 0x01000A00, which faults.
- Redirect (redirect_valid=1 at cycle t):
  - Clear out_valid and the skid entry. Discard the response arriving in cycle t, so pending is killed.
  - Clear fault.
  - If redirect_pc is legal: issue it in the same cycle (imem_rd=1, imem_addr=redirect_pc) and set pc_q <= redirect_pc+4. The first redirected instruction appears on out_* at t+2.
  - If redirect_pc is illegal: fault=1 and fault_pc=redirect_pc next cycle; no issue.
- Redirect has priority over dequeue and the issue rule in the same cycle. out_ready is ignored during a redirect cycle.
- While out_valid=1 and out_ready=0, out_instr and out_pc hold stable.
- imem_addr=pc_q whenever imem_rd=0 (don't-care to memory, kept deterministic).
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight response is ignored.

Decomposition:
- Shared package/defines: IMEM_BASE, IMEM_LAST, RESET_PC, and the word-size constant 4. Reuse the same constants that size the instruction memory array.
- One natural sub-module, fetch_skid_buf: the 2-entry output/skid buffer with valid/ready, {pc,instr} payload and flush.
- PC/issue logic stays in fetch_unit.

Test Plan:
- Reset release, out_ready=1, imem preloaded 0x00000013 everywhere → reads at 0x01000000, 0x01000004, …; out_valid rises 2 cycles after first issue; out_pc increments by 4 every cycle.
- out_ready=0 for 5 cycles mid-stream → at most 2 reads after the stall start; out_pc/out_instr stable; no instruction lost or duplicated after release.
- redirect_valid with redirect_pc=0x01000100 while 2 words buffered → out_valid=0 next cycle; imem_addr=0x01000100 in the redirect cycle; out_pc=0x01000100 two cycles later; stale words never appear.
- Sequential run to 0x010009FC → last out_pc=0x010009FC; fault=1 with fault_pc=0x01000A00; imem_rd stays 0.
- Redirect to 0x01000102 (misaligned) and to 0x00FFFFFC → fault=1 with fault_pc equal to the target; then redirect to 0x01000000 clears fault and resumes.
- rst asserted asynchronously mid-stall with skid full → out_valid, imem_rd and fault drop immediately; restart from 0x01000000.
